// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Transmit side of the UART. Bytes written by the host/DMA are buffered in a
//   synchronous FIFO and shifted out on tx as 8N1 frames: a start bit, eight
//   data bits LSB first, then one stop bit. Frames follow each other with no
//   idle gap while the FIFO has data.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per serial bit (>= 2)
//   ADDR_W       : FIFO address width, depth = 2**ADDR_W bytes
//
// Ports
//   clk_t     in   transmit clock, rising edge
//   rst_t     in   asynchronous active-high reset
//   wr_en     in   enqueue request for wr_data
//   wr_data   in   byte to enqueue
//   full      out  FIFO holds 2**ADDR_W bytes
//   empty     out  FIFO holds no bytes
//   count     out  number of stored bytes
//   overflow  out  one-cycle pulse when a write is dropped because full
//   tx        out  registered serial line, idles high
//   tx_busy   out  high while a frame is in progress
//   dma_txend out  one-cycle pulse during the last cycle of a stop bit
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 4
) (
  input  logic              clk_t,
  input  logic              rst_t,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              tx,
  output logic              tx_busy,
  output logic              dma_txend
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT     = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] PRE_LAST_CNT = CNT_W'(CLKS_PER_BIT - 2);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  clk_cnt_q, clk_cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              dma_txend_q, dma_txend_d;

  logic              wr_accept;
  logic              pop;
  logic              bit_done;
  logic [2:0]        bit_idx_next;

  // Flags come from registered count, so a pop in the same cycle cannot
  // make room for a write that arrives while full.
  assign full      = (count_q == (ADDR_W+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign wr_accept = wr_en & ~full;
  assign bit_done  = (clk_cnt_q == LAST_CNT);
  assign bit_idx_next = bit_idx_q + 3'd1;

  assign count     = count_q;
  assign overflow  = overflow_q;
  assign tx        = tx_q;
  assign tx_busy   = (state_q != IDLE);
  assign dma_txend = dma_txend_q;

  // FIFO storage has no reset; reset only clears the pointers and count,
  // which is enough to invalidate whatever was stored.
  always_ff @(posedge clk_t) begin
    if (wr_accept) begin
      mem_q[wptr_q] <= wr_data;
    end
  end

  // Frame sequencer. The pop is issued from here, and the byte is latched
  // into shift_q at the same edge so later writes cannot disturb it.
  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    dma_txend_d = 1'b0;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop       = 1'b1;
          shift_d   = mem_q[rptr_q];
          clk_cnt_d = '0;
          tx_d      = 1'b0;
          state_d   = START;
        end
      end
      START: begin
        if (bit_done) begin
          clk_cnt_d = '0;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
          state_d   = DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_done) begin
          clk_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_next;
            tx_d      = shift_q[bit_idx_next];
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        // dma_txend is registered, so it is raised one edge early to be
        // high exactly during the final stop-bit cycle.
        if (clk_cnt_q == PRE_LAST_CNT) begin
          dma_txend_d = 1'b1;
        end
        if (bit_done) begin
          clk_cnt_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rptr_q];
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // FIFO bookkeeping; a simultaneous write and pop leaves count unchanged.
  always_comb begin
    wptr_d     = wptr_q + ADDR_W'(wr_accept);
    rptr_d     = rptr_q + ADDR_W'(pop);
    overflow_d = wr_en & full;
    count_d    = count_q;
    if (wr_accept && !pop) begin
      count_d = count_q + (ADDR_W+1)'(1);
    end else if (pop && !wr_accept) begin
      count_d = count_q - (ADDR_W+1)'(1);
    end
  end

  always_ff @(posedge clk_t or posedge rst_t) begin
    if (rst_t) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      state_q     <= IDLE;
      clk_cnt_q   <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      tx_q        <= 1'b1;
      dma_txend_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      dma_txend_q <= dma_txend_d;
    end
  end

endmodule
